seg7_scan_ctrl: RTL

Avalon-MM slave that drives a multiplexed multi-digit 7-segment display for the stopwatch platform. Software writes one register per digit plus a control word. The block scans the digits round-robin with a programmable slot time and inserts an anti-ghosting blank interval at each slot start. Optional hex decode lets the CPU write BCD/hex nibbles instead of raw segment patterns.

---
 rtl/seg7_scan_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// Avalon-MM multiplexed 7-segment display driver: per-digit registers,
// round-robin digit scan with anti-ghosting blank interval and optional hex decode.
module seg7_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned BLANK      = 16,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [3:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] dig_sel
);

    localparam int unsigned CW = $clog2(SCAN_DIV);

    logic [6:0]            digit [8];
    logic                  en;
    logic                  dec;
    logic [CW-1:0]         cnt;
    logic [2:0]            idx;
    logic                  wr_en;
    logic                  en_next;
    logic                  blanking;
    logic [6:0]            pat;
    logic [6:0]            seg_i;
    logic [NUM_DIGITS-1:0] dig_i;
    logic                  unused_ok;

    assign unused_ok = ^writedata[31:7];
    assign wr_en     = chipselect && !write_n;
    assign blanking  = (cnt < CW'(BLANK));

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 8; i++) digit[i] <= '0;
            en  <= 1'b0;
            dec <= 1'b0;
        end else if (wr_en) begin
            if (32'(address) < NUM_DIGITS) digit[address[2:0]] <= writedata[6:0];
            else if (address == 4'd8) {dec, en} <= writedata[1:0];
        end
    end

    assign en_next = (wr_en && address == 4'd8) ? writedata[0] : en;

    // Hold the scan at 0 both while disabled and on the edge EN is cleared,
    // so a fresh enable always starts at slot 0 with a blank interval.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (!(en && en_next)) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CW'(SCAN_DIV - 1)) begin
            cnt <= '0;
            idx <= (idx == 3'(NUM_DIGITS - 1)) ? '0 : idx + 3'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_comb begin
        pat   = dec ? hex7(digit[idx][3:0]) : digit[idx];
        seg_i = '0;
        dig_i = '0;
        if (en && !blanking) begin
            seg_i = pat;
            for (int unsigned i = 0; i < NUM_DIGITS; i++)
                if (idx == 3'(i)) dig_i[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg     <= {7{ACTIVE_LOW}};
            dig_sel <= {NUM_DIGITS{ACTIVE_LOW}};
        end else begin
            seg     <= seg_i ^ {7{ACTIVE_LOW}};
            dig_sel <= dig_i ^ {NUM_DIGITS{ACTIVE_LOW}};
        end
    end

    // STATUS blanking flag reads 0 while disabled so an idle block reads all-zero.
    always_comb begin
        readdata = '0;
        if (32'(address) < NUM_DIGITS) readdata[6:0] = digit[address[2:0]];
        else if (address == 4'd8)      readdata[1:0] = {dec, en};
        else if (address == 4'd9)      readdata[3:0] = {en && blanking, idx};
    end

endmodule
